hydra_ingress_framer: RTL
=========================

# hydra_ingress_framer

Per-port store-and-forward packet framer sitting directly upstream of one `hydra` switch input. It accepts raw payload words from a valid/ready/last source, buffers each packet, and replays it on the switch's write protocol (`wr_sop` pulse, header word, payload words, `wr_eop` pulse). It prepends the 16-bit routing header {length, priority, destination} and honours the switch's `pause`. Oversized packets are dropped and counted.

## Interface
- `DEPTH`, 64: payload buffer depth in 16-bit words; power of two.
- `MAX_LEN`, 64: largest accepted payload length in words; must be ≤ DEPTH and ≤ 511.
- `DESC_DEPTH`, 4: descriptor FIFO depth (committed packets awaiting transmit).
- `clk`  in  1  single clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  source word valid.
- `s_ready`  out  1  framer accepts the word this cycle.
- `s_data`  in  16  payload word.
- `s_last`  in  1  final word of the packet.
- `s_dest`  in  4  destination port; sampled with the first word of a packet.
- `s_prio`  in  3  priority; sampled with the first word of a packet.
- `pause`  in  1  switch back-pressure for this port.
- `wr_sop`  out  1  start-of-packet pulse to the switch.
- `wr_vld`  out  1  `wr_data` valid.
- `wr_data`  out  16  header word, then payload words.
- `wr_eop`  out  1  end-of-packet pulse.
- `drop_cnt`  out  16  count of dropped oversized packets; saturates at 0xFFFF.

## Operation
- Header word is {len[8:0], prio[2:0], dest[3:0]}, MSB first. `len` is the payload word count, range 1..MAX_LEN; the header word itself is excluded.
- Ingress side:
  - A word transfers when `s_valid && s_ready`. Each word is written at `wptr`, `wptr` wraps modulo DEPTH, and `cur_len` increments.
  - On a transfer with `s_last`, a descriptor {len, prio, dest} is pushed and `pkt_start` becomes the new `wptr`.
  - If `cur_len` would exceed MAX_LEN, the packet enters DROP: `wptr` rewinds to `pkt_start`, buffer occupancy is restored, and words are accepted and discarded through `s_last`. `drop_cnt` increments once, on that last word. No descriptor is pushed.
- `s_ready` = !rst && occupancy < DEPTH && descriptor FIFO not full. In DROP, `s_ready` = 1 regardless of occupancy.
- Egress FSM:
  - IDLE → SOP when the descriptor FIFO is non-empty and `pause`==0.
  - SOP (`wr_sop`=1) → HDR (`wr_vld`=1, `wr_data`=header) → DATA (`wr_vld`=1, one buffered word per cycle, `len` cycles) → EOP (`wr_eop`=1) → IDLE.
  - The descriptor is popped in SOP. `rptr` advances once per DATA cycle, and occupancy decrements on each advance.
- `pause` is sampled only in IDLE. A packet already started is always completed without gaps.
- A simultaneous push and pop of the descriptor FIFO, or a buffer write and read in the same cycle, are both legal; occupancy nets to zero change.

## Timing
- Reset values:
  - `wr_sop`, `wr_vld`, `wr_eop`, `s_ready` = 0; `wr_data` = 0; `drop_cnt` = 0.
  - FSM = IDLE; all pointers, occupancy and the descriptor FIFO cleared.
- Reset mid-packet aborts both sides immediately. No `wr_eop` is issued for the aborted packet.
- Outputs are registered. Each packet occupies exactly len+3 consecutive cycles on the egress side: SOP, HDR, len × DATA, EOP.
- Earliest `wr_sop`: 2 cycles after the `s_last` transfer (1 cycle descriptor commit, 1 cycle IDLE decision). It is further delayed while `pause`=1.
- Back-to-back packets: the next `wr_sop` comes at the earliest 1 cycle after `wr_eop`, because IDLE always lasts ≥1 cycle.
- Buffer read is synchronous. The first payload word is prefetched in HDR, so DATA never stalls.
- `wr_sop`, `wr_vld` and `wr_eop` are mutually exclusive in every cycle.

## Structure
- Package `hydra_ingress_pkg` holds:
  - `hdr_t` packed struct {len[8:0], prio[2:0], dest[3:0]};
  - `desc_t` = `hdr_t`;
  - egress state enum {IDLE, SOP, HDR, DATA, EOP};
  - constants `LEN_W`=9, `PRIO_W`=3, `DEST_W`=4.
- Sub-module `hydra_sync_fifo`: a parameterised width/depth FIFO with full/empty flags, instantiated for the descriptor queue.
- The payload buffer is an inline register array with explicit pointers, because DROP needs pointer rewind.

## Test plan
- Single packet, 32 words, dest=3, prio=4, `pause`=0 → `wr_sop`, then header 0x1043, then the 32 words in order, then `wr_eop`. Total 35 cycles; `drop_cnt`=0.
- Three 4-word packets sent back-to-back → three framed packets with exactly one idle cycle between each `wr_eop` and the next `wr_sop`. Headers carry the correct dest/prio per packet.
- `pause`=1 held for 20 cycles with one packet committed → no `wr_sop` while paused. `wr_sop` fires 1 cycle after `pause` falls. Raising `pause` during DATA does not interrupt the packet.
- 65-word packet followed by a 2-word packet → `drop_cnt`=1. Only the 2-word packet appears (header len=2); buffer occupancy returns to 0.
- Fill the buffer (DEPTH words across packets) while `pause`=1 → `s_ready` drops at occupancy 64. It reasserts the cycle after the first DATA read once `pause` clears.
- Assert `rst` during DATA → all outputs 0 asynchronously. After release, a fresh packet is framed correctly with no residue.

Source files
------------

// File: rtl/hydra_ingress_pkg.sv
// Shared types and widths for the hydra ingress framer: routing header,
// descriptor and egress state encoding.
package hydra_ingress_pkg;
   localparam int LEN_W  = 9;
   localparam int PRIO_W = 3;
   localparam int DEST_W = 4;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [PRIO_W-1:0] prio;
      logic [DEST_W-1:0] dest;
   } hdr_t;

   typedef hdr_t desc_t;

   typedef enum logic [2:0] {IDLE, SOP, HDR, DATA, EOP} eg_state_t;

   function automatic hdr_t mk_hdr(input logic [LEN_W-1:0]  len,
                                   input logic [PRIO_W-1:0] prio,
                                   input logic [DEST_W-1:0] dest);
      hdr_t h;
      h.len  = len;
      h.prio = prio;
      h.dest = dest;
      return h;
   endfunction
endpackage

// File: rtl/hydra_ingress_framer_if.sv
// Source stream plus switch write port of one framer; slave is the framer
// view, master is the environment (source + switch) view.
interface hydra_ingress_framer_if;
   logic                                 s_valid;
   logic                                 s_ready;
   logic [hydra_ingress_pkg::DATA_W-1:0] s_data;
   logic                                 s_last;
   logic [hydra_ingress_pkg::DEST_W-1:0] s_dest;
   logic [hydra_ingress_pkg::PRIO_W-1:0] s_prio;
   logic                                 pause;
   logic                                 wr_sop;
   logic                                 wr_vld;
   logic [hydra_ingress_pkg::DATA_W-1:0] wr_data;
   logic                                 wr_eop;

   modport slave (
      input  s_valid, s_data, s_last, s_dest, s_prio, pause,
      output s_ready, wr_sop, wr_vld, wr_data, wr_eop
   );

   modport master (
      output s_valid, s_data, s_last, s_dest, s_prio, pause,
      input  s_ready, wr_sop, wr_vld, wr_data, wr_eop
   );
endinterface

// File: rtl/hydra_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and count-based
// full/empty flags; pushes while full and pops while empty are ignored.
module hydra_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [CW-1:0]    cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];

   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= (wp == LAST) ? '0 : wp + 1'b1;
         if (do_pop)  rp <= (rp == LAST) ? '0 : rp + 1'b1;
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/hydra_ingress_framer.sv
// Store-and-forward framer: buffers each source packet, then replays it to the
// switch as SOP, routing header, payload, EOP. Oversized packets are dropped.
module hydra_ingress_framer
   import hydra_ingress_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int MAX_LEN    = 64,
   parameter int DESC_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   hydra_ingress_framer_if.slave bus,
   output logic [CNT_W-1:0]      drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
   localparam logic [OW-1:0]    FULL_OCC = OW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wptr, pkt_start, rptr;
   logic [OW-1:0]     occ;
   logic [LEN_W-1:0]  cur_len;
   logic [PRIO_W-1:0] prio_q;
   logic [DEST_W-1:0] dest_q;
   logic              dropping;

   desc_t desc_in, desc_out;
   logic  desc_push, desc_pop, desc_full, desc_empty;

   logic ready, xfer, first, at_max, overflow, wr_en, rd_en, drop_evt;

   // ---------------- ingress ----------------
   assign first  = (cur_len == '0);
   assign at_max = !dropping && (cur_len == MAX_L);
   // A packet already holding MAX_LEN words must still see ready, otherwise a
   // MAX_LEN-sized packet filling the whole buffer could never reach its drop.
   assign ready  = !rst && (dropping || at_max || (occ < FULL_OCC && !desc_full));
   assign bus.s_ready = ready;

   assign xfer      = bus.s_valid && ready;
   assign overflow  = xfer && at_max;
   assign wr_en     = xfer && !dropping && !at_max;
   assign desc_push = wr_en && bus.s_last;
   assign drop_evt  = xfer && bus.s_last && (dropping || overflow);
   assign desc_in   = mk_hdr(cur_len + 1'b1,
                             first ? bus.s_prio : prio_q,
                             first ? bus.s_dest : dest_q);

   always_ff @(posedge clk)
      if (wr_en) mem[wptr] <= bus.s_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         pkt_start <= '0;
         cur_len   <= '0;
         prio_q    <= '0;
         dest_q    <= '0;
         dropping  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (first) begin
               prio_q <= bus.s_prio;
               dest_q <= bus.s_dest;
            end
            if (bus.s_last) begin
               pkt_start <= wptr + 1'b1;
               cur_len   <= '0;
            end else begin
               cur_len <= cur_len + 1'b1;
            end
         end
         // Rewind discards everything written for this packet so far.
         if (overflow) begin
            wptr     <= pkt_start;
            cur_len  <= '0;
            dropping <= !bus.s_last;
         end
         if (dropping && xfer && bus.s_last) dropping <= 1'b0;
         if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Occupancy counts every buffered word, committed or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ <= '0;
      else     occ <= occ + OW'(wr_en) - OW'(rd_en) - (overflow ? OW'(cur_len) : '0);
   end

   hydra_sync_fifo #(
      .WIDTH ($bits(desc_t)),
      .DEPTH (DESC_DEPTH)
   ) u_desc_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (desc_push),
      .din   (desc_in),
      .pop   (desc_pop),
      .dout  (desc_out),
      .full  (desc_full),
      .empty (desc_empty)
   );

   // ---------------- egress ----------------
   eg_state_t         state, state_nxt;
   logic [LEN_W-1:0]  tx_len, rd_cnt;
   logic              sop_q, vld_q, eop_q;
   logic [DATA_W-1:0] data_q;

   always_comb begin
      state_nxt = state;
      desc_pop  = 1'b0;
      rd_en     = 1'b0;
      unique case (state)
         IDLE: if (!desc_empty && !bus.pause) state_nxt = SOP;
         SOP: begin
            desc_pop  = 1'b1;
            state_nxt = HDR;
         end
         // First payload word is fetched while the header is on the bus.
         HDR: begin
            rd_en     = 1'b1;
            state_nxt = DATA;
         end
         DATA: begin
            if (rd_cnt == tx_len) state_nxt = EOP;
            else                  rd_en     = 1'b1;
         end
         EOP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         tx_len <= '0;
         rd_cnt <= '0;
         rptr   <= '0;
         sop_q  <= 1'b0;
         vld_q  <= 1'b0;
         eop_q  <= 1'b0;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         sop_q  <= (state_nxt == SOP);
         vld_q  <= (state_nxt == HDR) || (state_nxt == DATA);
         eop_q  <= (state_nxt == EOP);
         data_q <= '0;
         if (state == SOP) begin
            tx_len <= desc_out.len;
            rd_cnt <= '0;
            data_q <= desc_out;
         end
         if (rd_en) begin
            data_q <= mem[rptr];
            rptr   <= rptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

   assign bus.wr_sop  = sop_q;
   assign bus.wr_vld  = vld_q;
   assign bus.wr_eop  = eop_q;
   assign bus.wr_data = data_q;
endmodule
